// File: rtl/tspp_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and streak counter width.
package tspp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } arb_state_t;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/tspp_arb_grant.sv
// Combinational grant rule: data first, unless fetch has waited through MAX_D_STREAK data grants.
module tspp_arb_grant
  import tspp_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                iren,
  input  logic                dreq,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_i,
  output logic                grant_d
);

  logic starve;

  assign starve  = iren && (streak == STREAK_W'(MAX_D_STREAK));
  assign grant_d = dreq && !starve;
  assign grant_i = iren && !grant_d;

endmodule

// File: rtl/tspp_mem_arbiter.sv
// Shares one memory bus between the fetch and data ports; all bus outputs are registered.
// Handshake: a requester holds its request until its busy is low; the bus completes a strobe when bus_busy is low.
module tspp_mem_arbiter
  import tspp_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                iren,
  input  logic [ADDR_W-1:0]   iaddr,
  output logic [DATA_W-1:0]   irdata,
  output logic                i_busy,
  input  logic                dren,
  input  logic                dwen,
  input  logic [ADDR_W-1:0]   daddr,
  input  logic [DATA_W-1:0]   dwdata,
  input  logic [DATA_W/8-1:0] dbyte_en,
  output logic [DATA_W-1:0]   drdata,
  output logic                d_busy,
  output logic                bus_ren,
  output logic                bus_wen,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_byte_en,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_busy,
  output arb_state_t          dbg_state
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  logic                ren_q, ren_d, wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                abandon_q, abandon_d;

  logic dreq, take, owner_req, grant_i, grant_d, i_done, d_done;

  assign dreq = dren | dwen;

  tspp_arb_grant #(.MAX_D_STREAK(MAX_D_STREAK)) u_grant (
    .iren    (iren),
    .dreq    (dreq),
    .streak  (streak_q),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // A withdrawn owner still finishes on the bus but never sees its busy drop.
  assign i_done = (state_q == IBUS) && !bus_busy && iren && !abandon_q;
  assign d_done = (state_q == DBUS) && !bus_busy && dreq && !abandon_q;

  assign i_busy      = !i_done;
  assign d_busy      = !d_done;
  assign irdata      = i_done ? bus_rdata : '0;
  assign drdata      = d_done ? bus_rdata : '0;
  assign bus_ren     = ren_q;
  assign bus_wen     = wen_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_byte_en = be_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d   = state_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    abandon_d = abandon_q;
    streak_d  = streak_q;

    take      = (state_q == IDLE) || !bus_busy;
    owner_req = (state_q == IBUS) ? iren : dreq;

    if (state_q != IDLE && !owner_req) begin
      abandon_d = 1'b1;
    end

    if (take) begin
      abandon_d = 1'b0;
      if (grant_d) begin
        state_d = DBUS;
        ren_d   = dren;
        wen_d   = dwen;
        addr_d  = daddr;
        wdata_d = dwdata;
        be_d    = dbyte_en;
      end else if (grant_i) begin
        state_d = IBUS;
        ren_d   = 1'b1;
        wen_d   = 1'b0;
        addr_d  = iaddr;
        wdata_d = '0;
        be_d    = '1;
      end else begin
        state_d = IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
      end
    end

    // Streak only counts data grants that actually made fetch wait.
    if (!iren) begin
      streak_d = '0;
    end else if (take && grant_i) begin
      streak_d = '0;
    end else if (take && grant_d && streak_q < STREAK_W'(MAX_D_STREAK)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      streak_q  <= '0;
      abandon_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      streak_q  <= streak_d;
      abandon_q <= abandon_d;
    end
  end

endmodule

// File: tb/tb_tspp_mem_arbiter.sv
// Directed bench for tspp_mem_arbiter: reset, priority, anti-starvation, wait states, flush, back-to-back.
module tb_tspp_mem_arbiter;
  import tspp_arb_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iren, dren, dwen, bus_busy;
  logic [31:0] iaddr, daddr, dwdata, bus_rdata;
  logic [3:0]  dbyte_en;
  logic [31:0] irdata, drdata, bus_addr, bus_wdata;
  logic        i_busy, d_busy, bus_ren, bus_wen;
  logic [3:0]  bus_byte_en;
  arb_state_t  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  tspp_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iren(iren), .iaddr(iaddr), .irdata(irdata), .i_busy(i_busy),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dwdata(dwdata), .dbyte_en(dbyte_en),
    .drdata(drdata), .d_busy(d_busy),
    .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_byte_en(bus_byte_en), .bus_rdata(bus_rdata), .bus_busy(bus_busy),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    iren = 0; dren = 0; dwen = 0; bus_busy = 0;
    iaddr = '0; daddr = '0; dwdata = '0; dbyte_en = '0; bus_rdata = '0;
  endtask

  initial begin
    nRST = 0;
    idle_inputs();
    tick();
    settle();
    check("rst_ren", bus_ren, 0);
    check("rst_wen", bus_wen, 0);
    check("rst_ibusy", i_busy, 1);
    check("rst_dbusy", d_busy, 1);
    check("rst_addr", bus_addr, 0);
    check("rst_irdata", irdata, 0);
    check("rst_drdata", drdata, 0);
    #2 nRST = 1;

    // Reset in the middle of a data transfer aborts it immediately
    tick();
    dren = 1; daddr = 32'h40; bus_busy = 1;
    tick();
    check("mid_state", dbg_state, DBUS);
    check("mid_ren", bus_ren, 1);
    #2 nRST = 0;
    settle();
    check("abort_ren", bus_ren, 0);
    check("abort_wen", bus_wen, 0);
    check("abort_ibusy", i_busy, 1);
    check("abort_dbusy", d_busy, 1);
    check("abort_state", dbg_state, IDLE);
    idle_inputs();
    #2 nRST = 1;

    // First fetch after reset: strobe and completion one cycle after the request
    tick();
    iren = 1; iaddr = 32'h200; bus_rdata = 32'h1234_5678;
    settle();
    check("f0_ren", bus_ren, 0);
    check("f0_ibusy", i_busy, 1);
    tick();
    check("f1_ren", bus_ren, 1);
    check("f1_addr", bus_addr, 32'h200);
    check("f1_be", bus_byte_en, 4'hF);
    check("f1_ibusy", i_busy, 0);
    check("f1_irdata", irdata, 32'h1234_5678);
    iren = 0;
    tick();
    check("f2_idle", dbg_state, IDLE);
    check("f2_ren", bus_ren, 0);

    // Simultaneous requests: data first, then fetch with no idle bubble
    iren = 1; iaddr = 32'h100;
    dwen = 1; daddr = 32'h8000; dwdata = 32'hDEAD_BEEF; dbyte_en = 4'b0011;
    tick();
    check("pri_state", dbg_state, DBUS);
    check("pri_wen", bus_wen, 1);
    check("pri_ren", bus_ren, 0);
    check("pri_addr", bus_addr, 32'h8000);
    check("pri_wdata", bus_wdata, 32'hDEAD_BEEF);
    check("pri_be", bus_byte_en, 4'b0011);
    check("pri_dbusy", d_busy, 0);
    check("pri_ibusy", i_busy, 1);
    dwen = 0;
    tick();
    check("pri_i_state", dbg_state, IBUS);
    check("pri_i_addr", bus_addr, 32'h100);
    check("pri_i_be", bus_byte_en, 4'hF);
    check("pri_i_ibusy", i_busy, 0);
    iren = 0;
    tick();
    check("pri_idle", dbg_state, IDLE);

    // Anti-starvation: four data grants, one fetch, then data again
    exp_q.push_back(DBUS); exp_q.push_back(DBUS); exp_q.push_back(DBUS);
    exp_q.push_back(DBUS); exp_q.push_back(IBUS); exp_q.push_back(DBUS);
    iren = 1; iaddr = 32'h900; dren = 1; daddr = 32'h1000; bus_rdata = 32'h5555_0000;
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp_s;
      tick();
      exp_s = exp_q.pop_front();
      check("streak_state", dbg_state, exp_s);
      check("streak_ren", bus_ren, 1);
      if (exp_s == DBUS) begin
        check("streak_drdata", drdata, 32'h5555_0000);
      end else begin
        check("streak_iaddr", bus_addr, 32'h900);
      end
      daddr = daddr + 32'h4;
    end
    iren = 0; dren = 0;
    tick();
    check("streak_idle", dbg_state, IDLE);
    check("streak_q_empty", exp_q.size(), 0);

    // Wait states: address held, fetch busy until the fourth cycle
    iren = 1; iaddr = 32'h300; bus_busy = 1; bus_rdata = 32'hA5A5_0300;
    for (int c = 1; c <= 3; c++) begin
      tick();
      iaddr = 32'h300 + 32'(c) * 32'h10;
      settle();
      check("ws_addr", bus_addr, 32'h300);
      check("ws_ibusy", i_busy, 1);
    end
    tick();
    bus_busy = 0;
    settle();
    check("ws_done_ibusy", i_busy, 0);
    check("ws_done_addr", bus_addr, 32'h300);
    check("ws_irdata", irdata, 32'hA5A5_0300);
    iren = 0;
    tick();
    check("ws_idle", dbg_state, IDLE);

    // Flush: fetch withdraws mid-transfer; bus finishes and data is granted next
    iren = 1; iaddr = 32'h400; bus_busy = 1;
    tick();
    iren = 0; dren = 1; daddr = 32'h500;
    settle();
    check("fl_c1_ibusy", i_busy, 1);
    tick();
    check("fl_c2_ren", bus_ren, 1);
    check("fl_c2_addr", bus_addr, 32'h400);
    check("fl_c2_ibusy", i_busy, 1);
    tick();
    check("fl_c3_ibusy", i_busy, 1);
    tick();
    bus_busy = 0; iren = 1; iaddr = 32'h480;
    settle();
    check("fl_c4_state", dbg_state, IBUS);
    check("fl_c4_ibusy", i_busy, 1);
    check("fl_c4_irdata", irdata, 0);
    tick();
    check("fl_d_state", dbg_state, DBUS);
    check("fl_d_addr", bus_addr, 32'h500);
    check("fl_d_dbusy", d_busy, 0);
    dren = 0;
    tick();
    check("fl_i_state", dbg_state, IBUS);
    check("fl_i_addr", bus_addr, 32'h480);
    check("fl_i_ibusy", i_busy, 0);
    iren = 0;
    tick();
    check("fl_idle", dbg_state, IDLE);

    // Back-to-back reads then a write on the data port
    dren = 1; daddr = 32'h600;
    tick();
    check("bb_r0_ren", bus_ren, 1);
    check("bb_r0_wen", bus_wen, 0);
    check("bb_r0_addr", bus_addr, 32'h600);
    check("bb_r0_dbusy", d_busy, 0);
    daddr = 32'h604;
    tick();
    check("bb_r1_ren", bus_ren, 1);
    check("bb_r1_addr", bus_addr, 32'h604);
    check("bb_r1_dbusy", d_busy, 0);
    dren = 0; dwen = 1; daddr = 32'h608; dwdata = 32'hCAFE_F00D; dbyte_en = 4'hF;
    tick();
    check("bb_w_wen", bus_wen, 1);
    check("bb_w_ren", bus_ren, 0);
    check("bb_w_addr", bus_addr, 32'h608);
    check("bb_w_wdata", bus_wdata, 32'hCAFE_F00D);
    dwen = 0;
    tick();
    check("bb_idle_ren", bus_ren, 0);
    check("bb_idle_wen", bus_wen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
